// File: rtl/reorder_buffer_if.sv
// Bundle of the reorder buffer's issue, writeback, query, commit and flush signals.
// slave is the buffer side, master is the core/pipeline side.
`timescale 1ns/1ps
interface rob_if #(
  parameter int ROB_WIDTH = 3
);
  logic                 issue_valid;
  logic [4:0]           issue_rd_id;
  logic [ROB_WIDTH-1:0] issue_rob_idx;
  logic                 rob_full;

  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_idx;
  logic [31:0]          wb_val;
  logic                 wb_mispredict;
  logic [31:0]          wb_target;

  logic [ROB_WIDTH-1:0] query1_idx;
  logic [ROB_WIDTH-1:0] query2_idx;
  logic                 query1_ready;
  logic                 query2_ready;
  logic [31:0]          query1_val;
  logic [31:0]          query2_val;

  logic                 rob_to_rf_commit;
  logic [4:0]           rob_to_rf_reg_id;
  logic [31:0]          rob_to_rf_reg_val;
  logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx;

  logic                 clr_out;
  logic [31:0]          clr_pc_out;

  modport slave (
    input  issue_valid, issue_rd_id,
    output issue_rob_idx, rob_full,
    input  wb_valid, wb_rob_idx, wb_val, wb_mispredict, wb_target,
    input  query1_idx, query2_idx,
    output query1_ready, query2_ready, query1_val, query2_val,
    output rob_to_rf_commit, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx,
    output clr_out, clr_pc_out
  );

  modport master (
    output issue_valid, issue_rd_id,
    input  issue_rob_idx, rob_full,
    output wb_valid, wb_rob_idx, wb_val, wb_mispredict, wb_target,
    output query1_idx, query2_idx,
    input  query1_ready, query2_ready, query1_val, query2_val,
    input  rob_to_rf_commit, rob_to_rf_reg_id, rob_to_rf_reg_val, rob_to_rf_rob_idx,
    input  clr_out, clr_pc_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: tags 1..2^ROB_WIDTH-1 (tag 0 means "no dependency"),
// out-of-order writeback, combinational operand queries, mispredict flush on commit.
`timescale 1ns/1ps
module reorder_buffer #(
  parameter int ROB_WIDTH = 3
) (
  input  logic  clk_in,
  input  logic  rst_in,
  input  logic  rdy_in,
  rob_if.slave  bus
);
  localparam int unsigned          DEPTH = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH-1:0] CAP   = '1;
  localparam logic [ROB_WIDTH-1:0] FIRST = ROB_WIDTH'(1);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] mispredict;
  logic [4:0]       rd     [DEPTH];
  logic [31:0]      val    [DEPTH];
  logic [31:0]      target [DEPTH];

  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [ROB_WIDTH-1:0] count;
  logic [ROB_WIDTH-1:0] count_nxt;

  logic                 commit_q;
  logic [4:0]           reg_id_q;
  logic [31:0]          reg_val_q;
  logic [ROB_WIDTH-1:0] rob_idx_q;
  logic                 clr_q;
  logic [31:0]          clr_pc_q;

  logic issue_acc;
  logic wb_acc;
  logic commit_fire;
  logic flush;

  logic [ROB_WIDTH-1:0] q_idx   [2];
  logic                 q_ready [2];
  logic [31:0]          q_val   [2];

  function automatic logic [ROB_WIDTH-1:0] ptr_inc(input logic [ROB_WIDTH-1:0] p);
    return (p == CAP) ? FIRST : p + FIRST;
  endfunction

  // Commit looks only at registered ready, so a writeback to head retires one edge later.
  assign issue_acc   = rdy_in && bus.issue_valid && !bus.rob_full && !clr_q;
  assign wb_acc      = rdy_in && bus.wb_valid && !clr_q &&
                       (bus.wb_rob_idx != '0) && busy[bus.wb_rob_idx];
  assign commit_fire = rdy_in && !clr_q && busy[head] && ready[head];
  assign flush       = commit_fire && mispredict[head];

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (issue_acc && !commit_fire) begin
      count_nxt = count + FIRST;
    end else if (!issue_acc && commit_fire) begin
      count_nxt = count - FIRST;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy       <= '0;
      ready      <= '0;
      mispredict <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd[i]     <= '0;
        val[i]    <= '0;
        target[i] <= '0;
      end
      head      <= FIRST;
      tail      <= FIRST;
      count     <= '0;
      commit_q  <= 1'b0;
      reg_id_q  <= '0;
      reg_val_q <= '0;
      rob_idx_q <= '0;
      clr_q     <= 1'b0;
      clr_pc_q  <= '0;
    end else if (rdy_in) begin
      commit_q <= commit_fire;
      clr_q    <= flush;
      count    <= count_nxt;

      if (commit_fire) begin
        reg_id_q  <= rd[head];
        reg_val_q <= val[head];
        rob_idx_q <= head;
      end
      if (flush) begin
        clr_pc_q <= target[head];
      end

      if (wb_acc) begin
        ready[bus.wb_rob_idx]      <= 1'b1;
        val[bus.wb_rob_idx]        <= bus.wb_val;
        mispredict[bus.wb_rob_idx] <= bus.wb_mispredict;
        target[bus.wb_rob_idx]     <= bus.wb_target;
      end

      if (issue_acc && !flush) begin
        busy[tail]       <= 1'b1;
        ready[tail]      <= 1'b0;
        mispredict[tail] <= 1'b0;
        rd[tail]         <= bus.issue_rd_id;
        tail             <= ptr_inc(tail);
      end

      if (commit_fire) begin
        busy[head]       <= 1'b0;
        ready[head]      <= 1'b0;
        mispredict[head] <= 1'b0;
        head             <= ptr_inc(head);
      end

      // Later assignments win: a flush overrides the per-entry updates above.
      if (flush) begin
        busy       <= '0;
        ready      <= '0;
        mispredict <= '0;
        head       <= FIRST;
        tail       <= FIRST;
      end
    end
  end

  assign q_idx[0] = bus.query1_idx;
  assign q_idx[1] = bus.query2_idx;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      q_ready[p] = 1'b0;
      q_val[p]   = '0;
      if (q_idx[p] != '0) begin
        if (wb_acc && (bus.wb_rob_idx == q_idx[p])) begin
          q_ready[p] = 1'b1;
          q_val[p]   = bus.wb_val;
        end else if (busy[q_idx[p]] && ready[q_idx[p]]) begin
          q_ready[p] = 1'b1;
          q_val[p]   = val[q_idx[p]];
        end
      end
    end
  end

  assign bus.query1_ready = q_ready[0];
  assign bus.query1_val   = q_val[0];
  assign bus.query2_ready = q_ready[1];
  assign bus.query2_val   = q_val[1];

  assign bus.issue_rob_idx     = tail;
  assign bus.rob_full          = (count == CAP);
  assign bus.rob_to_rf_commit  = commit_q;
  assign bus.rob_to_rf_reg_id  = reg_id_q;
  assign bus.rob_to_rf_reg_val = reg_val_q;
  assign bus.rob_to_rf_rob_idx = rob_idx_q;
  assign bus.clr_out           = clr_q;
  assign bus.clr_pc_out        = clr_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed issue/writeback sequences push expected
// commits and flushes; a negedge monitor pops and compares whenever the DUT pulses.
`timescale 1ns/1ps
module tb_reorder_buffer;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  idx;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;
  logic rdy_at_edge = 1'b0;

  int checks   = 0;
  int failures = 0;

  exp_t        cq[$];
  logic [31:0] pq[$];
  exp_t        mon_e;
  logic [31:0] mon_pc;

  rob_if #(.ROB_WIDTH(3)) bus ();

  reorder_buffer #(.ROB_WIDTH(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) rdy_at_edge = rdy_in;

  always @(negedge clk_in) begin
    if (rdy_at_edge && bus.rob_to_rf_commit) begin
      checks++;
      if (cq.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected got rd=%0d val=%h idx=%0d required no commit",
                 bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_idx);
      end else begin
        mon_e = cq.pop_front();
        if (bus.rob_to_rf_reg_id !== mon_e.rd || bus.rob_to_rf_reg_val !== mon_e.val ||
            bus.rob_to_rf_rob_idx !== mon_e.idx) begin
          failures++;
          $display("FAIL commit got rd=%0d val=%h idx=%0d required rd=%0d val=%h idx=%0d",
                   bus.rob_to_rf_reg_id, bus.rob_to_rf_reg_val, bus.rob_to_rf_rob_idx,
                   mon_e.rd, mon_e.val, mon_e.idx);
        end
      end
    end
    if (rdy_at_edge && bus.clr_out) begin
      checks++;
      if (pq.size() == 0) begin
        failures++;
        $display("FAIL flush_unexpected got pc=%h required no flush", bus.clr_pc_out);
      end else begin
        mon_pc = pq.pop_front();
        if (bus.clr_pc_out !== mon_pc) begin
          failures++;
          $display("FAIL flush_pc got=%h required=%h", bus.clr_pc_out, mon_pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_c(input logic [4:0] rd, input logic [31:0] v, input logic [2:0] idx);
    exp_t e;
    e.rd  = rd;
    e.val = v;
    e.idx = idx;
    cq.push_back(e);
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [2:0] tag);
    chk("issue_tag", 32'(bus.issue_rob_idx), 32'(tag));
    bus.issue_valid = 1'b1;
    bus.issue_rd_id = rd;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [2:0] tag, input logic [31:0] v,
                       input logic mp, input logic [31:0] tgt);
    bus.wb_valid      = 1'b1;
    bus.wb_rob_idx    = tag;
    bus.wb_val        = v;
    bus.wb_mispredict = mp;
    bus.wb_target     = tgt;
    tick();
    bus.wb_valid      = 1'b0;
    bus.wb_mispredict = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.issue_valid   = 1'b0;
    bus.issue_rd_id   = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_rob_idx    = '0;
    bus.wb_val        = '0;
    bus.wb_mispredict = 1'b0;
    bus.wb_target     = '0;
    bus.query1_idx    = '0;
    bus.query2_idx    = '0;

    tick();
    tick();
    chk("rst_issue_idx", 32'(bus.issue_rob_idx), 32'd1);
    chk("rst_full", 32'(bus.rob_full), 32'd0);
    chk("rst_commit", 32'(bus.rob_to_rf_commit), 32'd0);
    chk("rst_clr", 32'(bus.clr_out), 32'd0);
    rst_in = 1'b1;
    tick();

    // Fill to capacity, reject an 8th issue, then wrap back to tag 1.
    for (int i = 1; i <= 7; i++) do_issue(5'(i), 3'(i));
    chk("full_after_7", 32'(bus.rob_full), 32'd1);
    chk("tail_wrapped", 32'(bus.issue_rob_idx), 32'd1);
    bus.issue_valid = 1'b1;
    bus.issue_rd_id = 5'd8;
    tick();
    bus.issue_valid = 1'b0;
    chk("issue8_rejected", 32'(bus.issue_rob_idx), 32'd1);
    chk("still_full", 32'(bus.rob_full), 32'd1);
    push_c(5'd1, 32'h1000, 3'd1);
    do_wb(3'd1, 32'h1000, 1'b0, 32'h0);
    tick();
    chk("not_full_after_commit", 32'(bus.rob_full), 32'd0);
    do_issue(5'd8, 3'd1);
    chk("full_again", 32'(bus.rob_full), 32'd1);

    // Full with head ready and issue pending: commit only, then issue+commit keeps count.
    push_c(5'd2, 32'h2000, 3'd2);
    do_wb(3'd2, 32'h2000, 1'b0, 32'h0);
    bus.issue_valid   = 1'b1;
    bus.issue_rd_id   = 5'd9;
    bus.wb_valid      = 1'b1;
    bus.wb_rob_idx    = 3'd3;
    bus.wb_val        = 32'h3000;
    push_c(5'd3, 32'h3000, 3'd3);
    tick();
    bus.wb_valid = 1'b0;
    chk("full_commit_only_full", 32'(bus.rob_full), 32'd0);
    chk("full_commit_only_tail", 32'(bus.issue_rob_idx), 32'd2);
    tick();
    chk("issue_commit_full", 32'(bus.rob_full), 32'd0);
    chk("issue_commit_tail", 32'(bus.issue_rob_idx), 32'd3);
    bus.issue_rd_id = 5'd10;
    tick();
    bus.issue_valid = 1'b0;
    chk("count_back_to_7", 32'(bus.rob_full), 32'd1);

    // Asynchronous reset mid-cycle, right after a commit pulse, with entries pending.
    push_c(5'd4, 32'h4000, 3'd4);
    do_wb(3'd4, 32'h4000, 1'b0, 32'h0);
    tick();
    chk("commit_pulse_pre_reset", 32'(bus.rob_to_rf_commit), 32'd1);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_rst_commit", 32'(bus.rob_to_rf_commit), 32'd0);
    chk("async_rst_issue_idx", 32'(bus.issue_rob_idx), 32'd1);
    chk("async_rst_full", 32'(bus.rob_full), 32'd0);
    tick();
    rst_in = 1'b1;

    // Out-of-order writeback, in-order commit.
    do_issue(5'd5, 3'd1);
    do_issue(5'd6, 3'd2);
    do_wb(3'd2, 32'h22, 1'b0, 32'h0);
    tick();
    tick();
    push_c(5'd5, 32'h11, 3'd1);
    push_c(5'd6, 32'h22, 3'd2);
    do_wb(3'd1, 32'h11, 1'b0, 32'h0);
    tick();
    tick();
    tick();

    // Query: not ready, same-cycle writeback bypass, then stored value.
    do_issue(5'd7, 3'd3);
    bus.query1_idx = 3'd3;
    bus.query2_idx = 3'd0;
    #1;
    chk("q1_not_ready", 32'(bus.query1_ready), 32'd0);
    chk("q1_not_ready_val", bus.query1_val, 32'h0);
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 3'd3;
    bus.wb_val     = 32'hABCD;
    #1;
    chk("q1_bypass_ready", 32'(bus.query1_ready), 32'd1);
    chk("q1_bypass_val", bus.query1_val, 32'hABCD);
    chk("q2_tag0_ready", 32'(bus.query2_ready), 32'd0);
    chk("q2_tag0_val", bus.query2_val, 32'h0);
    push_c(5'd7, 32'hABCD, 3'd3);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("q1_stored_ready", 32'(bus.query1_ready), 32'd1);
    chk("q1_stored_val", bus.query1_val, 32'hABCD);
    tick();
    #1;
    chk("q1_after_commit", 32'(bus.query1_ready), 32'd0);

    // Pause: a live commit pulse and all outputs freeze while rdy_in is low.
    do_issue(5'd12, 3'd4);
    push_c(5'd12, 32'h1234, 3'd4);
    do_wb(3'd4, 32'h1234, 1'b0, 32'h0);
    tick();
    rdy_in          = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_rd_id = 5'd13;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_commit", 32'(bus.rob_to_rf_commit), 32'd1);
      chk("pause_reg_val", bus.rob_to_rf_reg_val, 32'h1234);
      chk("pause_reg_id", 32'(bus.rob_to_rf_reg_id), 32'd12);
      chk("pause_issue_idx", 32'(bus.issue_rob_idx), 32'd5);
    end
    rdy_in          = 1'b1;
    bus.issue_valid = 1'b0;
    tick();
    chk("resume_commit_low", 32'(bus.rob_to_rf_commit), 32'd0);
    chk("resume_issue_idx", 32'(bus.issue_rob_idx), 32'd5);

    // Mispredict flush: tag1 commits, tags 2..4 are dropped, flush cycle ignores inputs.
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    for (int i = 1; i <= 4; i++) do_issue(5'(10 + i), 3'(i));
    do_wb(3'd2, 32'h66, 1'b0, 32'h0);
    push_c(5'd11, 32'h55, 3'd1);
    pq.push_back(32'h100);
    do_wb(3'd1, 32'h55, 1'b1, 32'h100);
    tick();
    chk("flush_clr", 32'(bus.clr_out), 32'd1);
    chk("flush_pc", bus.clr_pc_out, 32'h100);
    bus.issue_valid = 1'b1;
    bus.issue_rd_id = 5'd20;
    bus.wb_valid    = 1'b1;
    bus.wb_rob_idx  = 3'd3;
    bus.wb_val      = 32'h99;
    tick();
    bus.issue_valid = 1'b0;
    bus.wb_valid    = 1'b0;
    chk("flush_one_cycle", 32'(bus.clr_out), 32'd0);
    chk("flush_issue_ignored", 32'(bus.issue_rob_idx), 32'd1);
    chk("flush_no_commit", 32'(bus.rob_to_rf_commit), 32'd0);
    tick();
    tick();
    do_issue(5'd21, 3'd1);
    push_c(5'd21, 32'h77, 3'd1);
    do_wb(3'd1, 32'h77, 1'b0, 32'h0);
    tick();
    tick();

    chk("commits_drained", 32'(cq.size()), 32'd0);
    chk("flushes_drained", 32'(pq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 3; tag width. Tag 0 is reserved as "no dependency", so valid tags are 1..2^ROB_WIDTH-1 and capacity is CAP=2^ROB_WIDTH-1.
REQ-002 SHALL have one clock; reset is asynchronous and active-low. Ports below are listed as name, direction, width, meaning.
REQ-003 SHALL have clk_in, in, 1: system clock.
REQ-004 SHALL have rst_in, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have rdy_in, in, 1: pause; while low, all state and all registered outputs hold.
REQ-006 SHALL have issue_valid, in, 1; issue_rd_id, in, 5; issue_rob_idx, out, ROB_WIDTH (tag at tail); rob_full, out, 1.
REQ-007 SHALL have wb_valid, in, 1; wb_rob_idx, in, ROB_WIDTH; wb_val, in, 32; wb_mispredict, in, 1; wb_target, in, 32.
REQ-008 SHALL have query1_idx and query2_idx, in, ROB_WIDTH; query1_ready and query2_ready, out, 1; query1_val and query2_val, out, 32.
REQ-009 SHALL have rob_to_rf_commit, out, 1; rob_to_rf_reg_id, out, 5; rob_to_rf_reg_val, out, 32; rob_to_rf_rob_idx, out, ROB_WIDTH.
REQ-010 SHALL have clr_out, out, 1 (flush); clr_pc_out, out, 32 (redirect PC).

Function
REQ-011 Each entry SHALL hold: busy, ready, rd, val, mispredict, target. Pointers head and tail are in 1..CAP; count is in 0..CAP.
REQ-012 rob_full SHALL equal (count==CAP), taken from registered count with no same-cycle commit bypass.
REQ-013 issue_rob_idx SHALL equal tail combinationally.
REQ-014 Issue SHALL be accepted on a posedge when rdy_in && issue_valid && !rob_full && !clr_out. On accept: entry[tail] gets busy=1, ready=0, rd=issue_rd_id; tail advances.
REQ-015 Pointer increment SHALL wrap CAP -> 1; tag 0 is never produced.
REQ-016 Writeback SHALL, on a posedge with rdy_in && wb_valid && !clr_out && entry[wb_rob_idx].busy, set ready=1, val=wb_val, mispredict=wb_mispredict, target=wb_target. Writeback to a non-busy entry or to tag 0 SHALL be ignored.
REQ-017 Commit SHALL retire at most one entry per cycle, only entry[head], and only when it was busy && ready before the edge. A writeback to head in cycle N SHALL commit at edge N+1, not N.
REQ-018 On commit, the registered outputs SHALL pulse for exactly one cycle after the edge: rob_to_rf_commit=1, reg_id=rd, reg_val=val, rob_idx=head. The entry is cleared and head advances.
REQ-019 When the committed entry has mispredict=1, the same edge SHALL also clear every busy bit, set head=tail=1 and count=0. Registered clr_out=1 and clr_pc_out=target SHALL then hold for exactly one cycle.
REQ-020 While clr_out=1, issue and writeback SHALL be ignored and no commit occurs.
REQ-021 count SHALL follow these rules: +1 on issue only; -1 on commit only; unchanged on simultaneous issue and commit; forced to 0 on a mispredict commit, where a same-edge issue is dropped.
REQ-022 Query ports SHALL be combinational. queryN_ready = entry.busy && entry.ready, with queryN_val = entry.val. A same-cycle accepted writeback matching queryN_idx SHALL bypass (ready=1, val=wb_val). Tag 0 or a non-busy entry SHALL give ready=0, val=0.
REQ-023 Outputs not pulsing SHALL be 0: rob_to_rf_commit and clr_out deasserted, with their data fields held at their last values.

Reset
REQ-024 While rst_in=0, immediately and independently of clk_in: all busy/ready cleared, head=tail=1, count=0.
REQ-025 While rst_in=0, all registered outputs SHALL be 0; hence issue_rob_idx=1 and rob_full=0.
REQ-026 Reset SHALL take priority over rdy_in and all other inputs. The first accepted issue after release gets tag 1.

Verification
REQ-027 Bench SHALL cover fill and wrap: with ROB_WIDTH=3, issue 7 times (rd=1..7) -> tags 1..7 and rob_full=1. 8th issue rejected. After one commit, the next issue gets tag 1.
REQ-028 Bench SHALL cover out-of-order writeback: issue rd5 (tag1), rd6 (tag2). Write back tag2=0x22, then tag1=0x11 -> commits (rd5,0x11,tag1), then next cycle (rd6,0x22,tag2). No commit occurs before tag1 is ready.
REQ-029 Bench SHALL cover mispredict flush: issue tags 1..4, then write back tag1 with mispredict=1, target=0x100 -> tag1 commits. Following cycle: clr_out=1, clr_pc_out=0x100, and an issue in that cycle is ignored. Next accepted issue gets tag 1; tags 2..4 never commit.
REQ-030 Bench SHALL cover full with simultaneous events: rob_full=1, head ready, issue_valid=1 -> edge commits only and count becomes 6. Next cycle, issue plus commit -> count stays 6.
REQ-031 Bench SHALL cover query bypass: query1_idx=3 while wb_rob_idx=3, wb_val=0xABCD -> query1_ready=1 and query1_val=0xABCD in the same cycle. query2_idx=0 -> query2_ready=0.
REQ-032 Bench SHALL cover asynchronous reset: drop rst_in mid-cycle with entries pending -> count=0, rob_to_rf_commit=0, issue_rob_idx=1 before the next clk_in edge. rdy_in=0 for 3 cycles SHALL freeze all outputs.
